// File: rtl/timer_dev_pkg.sv
// Shared definitions for the bus timer: register map, CTRL field layout,
// mode encodings and the sequencer state type.
package timer_dev_pkg;

   // Word offsets on the device's local address (bus address bits [3:2])
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   // CTRL field positions; only the low CTRL_W bits are implemented
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_W        = 4;

   // Mode encodings; 2'b10 and 2'b11 are treated as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   // Only the exact reload encoding selects auto-reload
   function automatic logic is_reload(input logic [1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage

// File: rtl/timer_dev_if.sv
// Register bus between the address decoder (master) and the timer (slave),
// plus the interrupt line heading to the CPU's hardware interrupt inputs.
interface timer_dev_if #(
   parameter int DW = 32
);
   logic [1:0]    addr;   // word offset
   logic          we;     // write strobe, already qualified for this device
   logic [DW-1:0] din;    // store data
   logic [DW-1:0] dout;   // read data, combinational from addr
   logic          irq;    // registered interrupt request

   modport master (
      output addr,
      output we,
      output din,
      input  dout,
      input  irq
   );

   modport slave (
      input  addr,
      input  we,
      input  din,
      output dout,
      output irq
   );
endinterface

// File: rtl/timer_dev.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Software sees CTRL / PRESET / COUNT; the sequencer walks
// IDLE -> LOAD -> CNT -> INT and raises a maskable interrupt on expiry.
//
// Control decisions use the CTRL value as it will be after the current edge,
// so a write that sets EN moves IDLE to LOAD on that same edge, and a write
// that clears EN stops the count on that same edge (COUNT holds its value).
module timer_dev
   import timer_dev_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic        clk,
   input  logic        rst,
   timer_dev_if.slave  bus
);

   localparam logic [DW-1:0] CNT_ONE  = DW'(1);
   localparam logic [DW-1:0] CNT_ZERO = '0;

   // Architectural state
   logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
   logic [DW-1:0]     preset_q, preset_d;
   logic [DW-1:0]     count_q,  count_d;
   state_t            state_q,  state_d;
   logic              irq_flag_q, irq_flag_d;
   logic              irq_q,      irq_d;

   // Decoded bus writes
   logic              wr_ctrl;
   logic              wr_preset;

   // CTRL as software leaves it after this edge, before any hardware clear
   logic [CTRL_W-1:0] ctrl_sw;
   logic              en_eff;
   logic              reload_eff;

   assign wr_ctrl    = bus.we && (bus.addr == ADDR_CTRL);
   assign wr_preset  = bus.we && (bus.addr == ADDR_PRESET);
   assign ctrl_sw    = wr_ctrl ? bus.din[CTRL_W-1:0] : ctrl_q;
   assign en_eff     = ctrl_sw[CTRL_EN_BIT];
   assign reload_eff = is_reload(ctrl_sw[CTRL_MODE_MSB:CTRL_MODE_LSB]);

   // Next-state logic for the sequencer, counter, CTRL and interrupt flag
   always_comb begin
      ctrl_d     = ctrl_sw;
      preset_d   = wr_preset ? bus.din : preset_q;
      count_d    = count_q;
      state_d    = state_q;
      irq_flag_d = irq_flag_q;

      // Any software access to CTRL or PRESET acknowledges a pending flag;
      // an expiry on the same edge overrides this below.
      if (wr_ctrl || wr_preset) begin
         irq_flag_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (en_eff) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (!en_eff) begin
               state_d = ST_IDLE;
            end else begin
               // PRESET sampled here, so mid-count writes wait for the next LOAD
               count_d = preset_q;
               state_d = ST_CNT;
            end
         end

         ST_CNT: begin
            if (!en_eff) begin
               state_d = ST_IDLE;
            end else if (count_q > CNT_ONE) begin
               count_d = count_q - CNT_ONE;
            end else begin
               // Values 0 and 1 both expire here
               count_d    = CNT_ZERO;
               irq_flag_d = 1'b1;
               state_d    = ST_INT;
            end
         end

         ST_INT: begin
            if (!en_eff) begin
               state_d = ST_IDLE;
            end else if (reload_eff) begin
               irq_flag_d = 1'b0;
               state_d    = ST_LOAD;
            end else if (wr_ctrl) begin
               // Software re-armed EN on the very edge hardware would clear it
               state_d = ST_LOAD;
            end else begin
               ctrl_d[CTRL_EN_BIT] = 1'b0;
               state_d             = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      irq_d = irq_flag_d & ctrl_d[CTRL_IM_BIT];
   end

   // Register update; reset clears everything without waiting for a clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= '0;
         preset_q   <= '0;
         count_q    <= '0;
         state_q    <= ST_IDLE;
         irq_flag_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         state_q    <= state_d;
         irq_flag_q <= irq_flag_d;
         irq_q      <= irq_d;
      end
   end

   // Read mux; unimplemented CTRL bits and the unmapped offset read as zero
   always_comb begin
      bus.dout = '0;
      unique case (bus.addr)
         ADDR_CTRL:   bus.dout = DW'(ctrl_q);
         ADDR_PRESET: bus.dout = preset_q;
         ADDR_COUNT:  bus.dout = count_q;
         default:     bus.dout = '0;
      endcase
   end

   assign bus.irq = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: each task drives one scenario and checks
// register reads and irq against hand-derived expectations.
module tb_timer_dev;
   import timer_dev_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   timer_dev_if #(.DW(32)) bus ();

   timer_dev #(.DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; leave the bench 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.addr = a;
      bus.din  = d;
      bus.we   = 1'b1;
      tick();
      bus.we   = 1'b0;
      $display("wr addr=%0d data=0x%08h", a, d);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      bus.addr = a;
      #1;
      d = bus.dout;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1; bus.we = 1'b0; bus.addr = 2'd0; bus.din = '0;
      #2;
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", bus.irq); end
      rd(ADDR_CTRL, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl: got 0x%h expected 0", d); end
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_count: got 0x%h expected 0", d); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      wr(ADDR_PRESET, 32'd5);
      wr(ADDR_CTRL, 32'h9);
      for (int i = 0; i < 6; i++) begin
         tick();
         rd(ADDR_COUNT, d);
         checks++; if (d !== 32'(5 - i)) begin failures++; $display("FAIL oneshot_count step %0d: got %0d expected %0d", i, d, 5 - i); end
         if (i < 5) begin
            checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL oneshot_early_irq step %0d: got %b expected 0", i, bus.irq); end
         end
      end
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_at_expiry: got %b expected 1", bus.irq); end
      tick();
      rd(ADDR_CTRL, d);
      checks++; if (d !== 32'h8) begin failures++; $display("FAIL oneshot_en_cleared: got 0x%h expected 0x8", d); end
      tick();
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_held: got %b expected 1", bus.irq); end
      wr(ADDR_PRESET, 32'd3);
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_ack: got %b expected 0", bus.irq); end
   endtask

   task automatic test_reload();
      logic [31:0] d;
      logic [31:0] exp_cnt [10];
      logic        exp_irq [10];
      exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      wr(ADDR_PRESET, 32'd3);
      wr(ADDR_CTRL, 32'hB);
      for (int i = 0; i < 10; i++) begin
         tick();
         rd(ADDR_COUNT, d);
         checks++; if (d !== exp_cnt[i]) begin failures++; $display("FAIL reload_count cycle %0d: got %0d expected %0d", i, d, exp_cnt[i]); end
         checks++; if (bus.irq !== exp_irq[i]) begin failures++; $display("FAIL reload_irq cycle %0d: got %b expected %b", i, bus.irq, exp_irq[i]); end
      end
      wr(ADDR_CTRL, 32'h0);
   endtask

   task automatic test_masked();
      logic [31:0] d;
      wr(ADDR_PRESET, 32'd2);
      wr(ADDR_CTRL, 32'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL masked_irq cycle %0d: got %b expected 0", i, bus.irq); end
      end
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL masked_count: got %0d expected 0", d); end
      wr(ADDR_CTRL, 32'h8);
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL masked_unmask_irq: got %b expected 0", bus.irq); end
   endtask

   task automatic test_disable();
      logic [31:0] d;
      wr(ADDR_PRESET, 32'd10);
      wr(ADDR_CTRL, 32'h9);
      for (int i = 0; i < 5; i++) tick();
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd6) begin failures++; $display("FAIL disable_pre: got %0d expected 6", d); end
      wr(ADDR_CTRL, 32'h8);
      tick();
      tick();
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd6) begin failures++; $display("FAIL disable_frozen: got %0d expected 6", d); end
      wr(ADDR_CTRL, 32'h9);
      tick();
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd10) begin failures++; $display("FAIL disable_reload: got %0d expected 10", d); end
      wr(ADDR_CTRL, 32'h0);
   endtask

   task automatic test_ignored_writes();
      logic [31:0] d;
      wr(ADDR_COUNT, 32'hFFFF);
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd10) begin failures++; $display("FAIL count_readonly: got %0d expected 10", d); end
      wr(2'd3, 32'hFFFF);
      rd(2'd3, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL addr3_read: got 0x%h expected 0", d); end
      rd(ADDR_PRESET, d);
      checks++; if (d !== 32'd10) begin failures++; $display("FAIL preset_untouched: got %0d expected 10", d); end
      rd(ADDR_CTRL, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL ctrl_untouched: got 0x%h expected 0", d); end
   endtask

   task automatic test_preset_zero();
      wr(ADDR_PRESET, 32'd0);
      wr(ADDR_CTRL, 32'h9);
      tick();
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL preset0_load: got %b expected 0", bus.irq); end
      tick();
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL preset0_expiry: got %b expected 1", bus.irq); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      // Re-arm in the INT cycle: software EN wins over the hardware clear
      wr(ADDR_PRESET, 32'd2);
      wr(ADDR_CTRL, 32'h9);
      tick(); tick(); tick();
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL b2b_expiry: got %b expected 1", bus.irq); end
      wr(ADDR_CTRL, 32'h9);
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL b2b_ack: got %b expected 0", bus.irq); end
      rd(ADDR_CTRL, d);
      checks++; if (d !== 32'h9) begin failures++; $display("FAIL b2b_ctrl: got 0x%h expected 0x9", d); end
      tick();
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd2) begin failures++; $display("FAIL b2b_reloaded: got %0d expected 2", d); end
      tick();
      // PRESET write on the expiry edge: the flag set wins
      wr(ADDR_PRESET, 32'd7);
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL setwins_irq: got %b expected 1", bus.irq); end
      rd(ADDR_PRESET, d);
      checks++; if (d !== 32'd7) begin failures++; $display("FAIL setwins_preset: got %0d expected 7", d); end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d;
      tick();
      wr(ADDR_CTRL, 32'h9);
      tick();
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd7) begin failures++; $display("FAIL midreset_pre: got %0d expected 7", d); end
      rst = 1'b1;
      #1;
      checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL midreset_irq: got %b expected 0", bus.irq); end
      rd(ADDR_COUNT, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL midreset_count: got %0d expected 0", d); end
      rd(ADDR_CTRL, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL midreset_ctrl: got 0x%h expected 0", d); end
      rd(ADDR_PRESET, d);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL midreset_preset: got %0d expected 0", d); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_oneshot();
      test_reload();
      test_masked();
      test_disable();
      test_ignored_writes();
      test_preset_zero();
      test_back_to_back();
      test_reset_midcount();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
